mor1kx_rf_multiport: RTL and testbench
======================================

# mor1kx_rf_multiport

Parametrised GPR file for the cappuccino-class pipeline, the successor to the fixed two-port register file. It provides NUM_RD synchronous read ports with per-port hold-and-capture tracking, forwarding from NUM_BYP pipeline stages, and NUM_BANKS shadow/context banks. It also adds an optional hardwired r0, a sequenced SPR GPR access port, and a post-reset clearing sequencer. It sits between fetch/decode (reads), the downstream stages (forwarding) and writeback, and serves the SPR bus for debug and shadow access.

## Interface
- OPTION_OPERAND_WIDTH, 32, data width W
- OPTION_RF_ADDR_WIDTH, 5, per-bank address width A
- NUM_RD, 2, read ports (1..4)
- NUM_BYP, 2, forwarding sources; index 0 is youngest
- NUM_BANKS, 1, power of 2; C = clog2(NUM_BANKS), minimum 1 bit
- OPTION_R0_ZERO, 1, reads of r0 return 0 and writes to r0 are dropped
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rd_en_i  in  1  latch new read addresses (fetch advance)
- rd_adr_i  in  NUM_RD*A  read addresses; port k uses bits [k*A +: A]
- rd_dat_o  out  NUM_RD*W  read data, forwarded
- ctx_i  in  C  active bank, for reads and wb writes
- byp_valid_i  in  NUM_BYP  stage s holds a pending GPR write
- byp_adr_i  in  NUM_BYP*A  stage s destination
- byp_dat_i  in  NUM_BYP*W  stage s result
- wb_we_i, wb_adr_i[A], wb_dat_i[W]  in  writeback
- spr_bus_addr_i[16], spr_bus_stb_i, spr_bus_we_i, spr_bus_dat_i[W]  in  SPR bus
- spr_gpr_ack_o  out  1  SPR access done
- spr_gpr_dat_o  out  W  SPR read data, valid with ack
- init_done_o  out  1  clearing sequence finished

## Operation
- Storage: NUM_BANKS*2^A words. Physical address = {bank, adr}.
- Clear FSM, states CLEAR and RUN:
  - Reset enters CLEAR with counter 0. Each cycle writes 0 to the counter address and increments it.
  - After the last word is written, moves to RUN. init_done_o goes 1.
  - In CLEAR: wb_we_i and SPR requests are ignored, and all outputs are 0.
- Read port k, RUN:
  - On rd_en_i, latch {ctx_i, adr_k} as held_k and start the RAM read.
  - If wb_we_i hits the same physical address in the latch cycle, set cap_k = 1 and store wb_dat_i (RAM returns old data on read-during-write).
  - Otherwise cap_k = 0.
  - While rd_en_i = 0, any wb write to held_k sets cap_k and overwrites the stored value.
- rd_dat_o[k] priority, highest first:
  - OPTION_R0_ZERO and held adr = 0 → 0
  - lowest s with byp_valid_i[s] and byp_adr_i[s] == held adr (current bank) → byp_dat_i[s]
  - wb_we_i hitting held_k → wb_dat_i
  - cap_k → captured value
  - otherwise RAM data
- Forwarding sources are treated as belonging to ctx_i.
- SPR window: spr_bus_addr_i[15:9] == 7'h2, bank = addr[A+C-1:A], word = addr[A-1:0].
- SPR FSM, states IDLE, RD, ACK:
  - Write: in IDLE with stb & we & !wb_we_i, write the RAM and ack in the same cycle. If wb_we_i is set, the write waits with no ack.
  - Read: IDLE → RD (dedicated read port issued) → ACK. ack = 1 for one cycle, dat_o valid, then → IDLE.
  - A wb write to the same address during RD is forwarded into dat_o.
  - stb dropping in RD aborts to IDLE with no ack.
- spr_gpr_ack_o and spr_gpr_dat_o are 0 outside ACK and write-ack cycles. Requests outside the window are never acked.

## Timing
- Reset values: rd_dat_o = 0, spr_gpr_ack_o = 0, spr_gpr_dat_o = 0, init_done_o = 0. Clear FSM in CLEAR, SPR FSM in IDLE, all cap_k = 0.
- Reset mid-operation restarts the clear sequence and aborts any SPR access.
- Clear takes NUM_BANKS*2^A cycles; init_done_o rises on the following edge.
- Read latency: 1 cycle from rd_en_i. Forwarding paths are combinational within the output cycle.
- SPR write latency 0 cycles. SPR read latency 2 cycles: ack in the 3rd cycle of stb.
- wb write visible in RAM on the next edge.
- Simultaneous SPR write and wb write: wb wins, the SPR write stalls.

## Structure
- Shared constants go in mor1kx-defines.v: the GPR SPR group (7'h2) and the SPR FSM state encodings.
- Sub-module mor1kx_rf_rdport: held address, capture register and priority mux, generated NUM_RD times.
- Storage: one mor1kx_rf_ram per read port plus one for the SPR port, sharing a single write port. The write mux priority is clear > wb > SPR.

## Test plan
- Reset, then wait → init_done_o rises after exactly 32 cycles (NUM_BANKS=1, A=5); a read of r7 returns 0.
- wb writes r3=0x1234 in the same cycle rd_en_i latches r3 → rd_dat_o[0] = 0x1234 next cycle. A later wb r3=0x55 with rd_en_i low → 0x55.
- Held r5 with byp_valid_i = 2'b11, byp_dat_i = {0xB, 0xA}, wb r5=0xC → output 0xA. Drop byp 0 → 0xB. Drop both → 0xC.
- OPTION_R0_ZERO=1: wb r0=0xFFFF and byp to r0 → reads of r0 return 0.
- NUM_BANKS=2: SPR write 0x400+32+4 = 0xDEAD, ctx_i=1, read r4 → 0xDEAD. With ctx_i=0, r4 → 0.
- SPR read of 0x404 with wb r4=0x77 issued in the RD cycle → ack in cycle 3 with dat 0x77. An SPR write colliding with wb_we_i → no ack until wb_we_i drops.

Source files
------------

// File: rtl/mor1kx_rf_multiport_pkg.sv
// Shared constants and state encodings for the multiport GPR file.
// Also provides the bank-select width helper.
package mor1kx_rf_multiport_pkg;

    localparam logic [6:0] SPR_GROUP_GPR = 7'h2;

    typedef enum logic {
        CLR_CLEAR = 1'b0,
        CLR_RUN   = 1'b1
    } clr_state_t;

    typedef enum logic [1:0] {
        SPR_IDLE = 2'd0,
        SPR_RD   = 2'd1,
        SPR_ACK  = 2'd2
    } spr_state_t;

    // A single bank still carries a one-bit (always zero) bank field.
    function automatic int ctx_width(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/mor1kx_rf_multiport_rdport.sv
// One GPR read port: held physical address, write-capture register and
// the output priority mux (r0, forwarding, writeback, capture, RAM).
module mor1kx_rf_multiport_rdport
    import mor1kx_rf_multiport_pkg::*;
#(
    parameter int W       = 32,
    parameter int A       = 5,
    parameter int CW      = 1,
    parameter int NUM_BYP = 2,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 rd_en,
    input  logic [A-1:0]         rd_adr,
    input  logic [CW-1:0]        ctx,
    input  logic [W-1:0]         ram_dat,
    input  logic                 wb_wr,
    input  logic [CW+A-1:0]      wb_phys,
    input  logic [W-1:0]         wb_dat,
    input  logic [NUM_BYP-1:0]   byp_valid,
    input  logic [NUM_BYP*A-1:0] byp_adr,
    input  logic [NUM_BYP*W-1:0] byp_dat,
    output logic [W-1:0]         rd_dat
);

    logic [CW+A-1:0] held_r;
    logic            cap_r;
    logic [W-1:0]    cap_dat_r;
    logic [W-1:0]    ram_q_r;
    logic            wb_hit_s;
    logic            byp_hit_s;
    logic [W-1:0]    byp_val_s;

    assign wb_hit_s = wb_wr && (wb_phys == held_r);

    // Latch address and RAM word; capture writeback that the RAM read misses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_r    <= {(CW+A){1'b0}};
            cap_r     <= 1'b0;
            cap_dat_r <= {W{1'b0}};
            ram_q_r   <= {W{1'b0}};
        end else if (run && rd_en) begin
            held_r    <= {ctx, rd_adr};
            ram_q_r   <= ram_dat;
            cap_r     <= wb_wr && (wb_phys == {ctx, rd_adr});
            cap_dat_r <= wb_dat;
        end else if (run && wb_hit_s) begin
            cap_r     <= 1'b1;
            cap_dat_r <= wb_dat;
        end else begin
            cap_r     <= cap_r;
            cap_dat_r <= cap_dat_r;
        end
    end

    // Youngest matching forwarding stage in the active bank.
    always_comb begin
        byp_hit_s = 1'b0;
        byp_val_s = {W{1'b0}};
        for (int s = 0; s < NUM_BYP; s++) begin
            if (!byp_hit_s && byp_valid[s] &&
                (byp_adr[s*A +: A] == held_r[A-1:0]) &&
                (held_r[CW+A-1:A] == ctx)) begin
                byp_hit_s = 1'b1;
                byp_val_s = byp_dat[s*W +: W];
            end else begin
                byp_hit_s = byp_hit_s;
            end
        end
    end

    // Output priority mux.
    always_comb begin
        rd_dat = {W{1'b0}};
        if (!run) begin
            rd_dat = {W{1'b0}};
        end else if (R0_ZERO && (held_r[A-1:0] == {A{1'b0}})) begin
            rd_dat = {W{1'b0}};
        end else if (byp_hit_s) begin
            rd_dat = byp_val_s;
        end else if (wb_hit_s) begin
            rd_dat = wb_dat;
        end else if (cap_r) begin
            rd_dat = cap_dat_r;
        end else begin
            rd_dat = ram_q_r;
        end
    end

endmodule

// File: rtl/mor1kx_rf_multiport.sv
// Parametrised GPR file: banked storage, NUM_RD forwarding read ports,
// post-reset clearing sequencer and a sequenced SPR access port.
module mor1kx_rf_multiport
    import mor1kx_rf_multiport_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int NUM_RD               = 2,
    parameter int NUM_BYP              = 2,
    parameter int NUM_BANKS            = 1,
    parameter int OPTION_R0_ZERO       = 1,
    localparam int W  = OPTION_OPERAND_WIDTH,
    localparam int A  = OPTION_RF_ADDR_WIDTH,
    localparam int CW = ctx_width(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_en_i,
    input  logic [NUM_RD*A-1:0]  rd_adr_i,
    output logic [NUM_RD*W-1:0]  rd_dat_o,
    input  logic [CW-1:0]        ctx_i,
    input  logic [NUM_BYP-1:0]   byp_valid_i,
    input  logic [NUM_BYP*A-1:0] byp_adr_i,
    input  logic [NUM_BYP*W-1:0] byp_dat_i,
    input  logic                 wb_we_i,
    input  logic [A-1:0]         wb_adr_i,
    input  logic [W-1:0]         wb_dat_i,
    input  logic [15:0]          spr_bus_addr_i,
    input  logic                 spr_bus_stb_i,
    input  logic                 spr_bus_we_i,
    input  logic [W-1:0]         spr_bus_dat_i,
    output logic                 spr_gpr_ack_o,
    output logic [W-1:0]         spr_gpr_dat_o,
    output logic                 init_done_o
);

    localparam int              PA       = CW + A;
    localparam int              DEPTH    = NUM_BANKS * (2 ** A);
    localparam logic [PA-1:0]   CLR_LAST = PA'(DEPTH - 1);
    localparam bit              R0Z      = (OPTION_R0_ZERO != 0);

    clr_state_t      clr_state_r, clr_next_s;
    spr_state_t      spr_state_r, spr_next_s;
    logic [PA-1:0]   clr_cnt_r;
    logic            init_done_r;
    logic [W-1:0]    spr_q_r;
    logic [W-1:0]    mem_r [2**PA];

    logic            run_s;
    logic [CW-1:0]   ctx_eff_s, spr_bank_s;
    logic [PA-1:0]   wb_phys_s, spr_phys_s, mem_wa_s;
    logic            wb_wr_s, spr_in_win_s, spr_wr_req_s, mem_we_s;
    logic [W-1:0]    mem_wd_s, spr_rd_val_s;
    logic [W-1:0]    ram_rd_s [NUM_RD];

    assign run_s        = (clr_state_r == CLR_RUN);
    assign ctx_eff_s    = (NUM_BANKS > 1) ? ctx_i : {CW{1'b0}};
    assign spr_bank_s   = (NUM_BANKS > 1) ? spr_bus_addr_i[A+CW-1:A] : {CW{1'b0}};
    assign spr_phys_s   = {spr_bank_s, spr_bus_addr_i[A-1:0]};
    assign spr_in_win_s = (spr_bus_addr_i[15:9] == SPR_GROUP_GPR);
    assign wb_phys_s    = {ctx_eff_s, wb_adr_i};
    assign wb_wr_s      = run_s && wb_we_i && !(R0Z && (wb_adr_i == {A{1'b0}}));
    // wb_we_i stalls an SPR write even when the wb write itself targets r0.
    assign spr_wr_req_s = run_s && (spr_state_r == SPR_IDLE) && spr_bus_stb_i &&
                          spr_bus_we_i && spr_in_win_s && !wb_we_i;
    assign spr_rd_val_s = (wb_wr_s && (wb_phys_s == spr_phys_s)) ? wb_dat_i : mem_r[spr_phys_s];

    // Clear and SPR state registers, clear counter, init flag and SPR read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_state_r <= CLR_CLEAR;
            clr_cnt_r   <= {PA{1'b0}};
            init_done_r <= 1'b0;
            spr_state_r <= SPR_IDLE;
            spr_q_r     <= {W{1'b0}};
        end else begin
            clr_state_r <= clr_next_s;
            clr_cnt_r   <= run_s ? clr_cnt_r : clr_cnt_r + {{(PA-1){1'b0}}, 1'b1};
            init_done_r <= (clr_next_s == CLR_RUN);
            spr_state_r <= spr_next_s;
            spr_q_r     <= (spr_state_r == SPR_RD) ? spr_rd_val_s : spr_q_r;
        end
    end

    // Clear sequencer next state.
    always_comb begin
        clr_next_s = clr_state_r;
        case (clr_state_r)
            CLR_CLEAR: clr_next_s = (clr_cnt_r == CLR_LAST) ? CLR_RUN : CLR_CLEAR;
            CLR_RUN:   clr_next_s = CLR_RUN;
            default:   clr_next_s = CLR_CLEAR;
        endcase
    end

    // SPR access sequencer next state.
    always_comb begin
        spr_next_s = spr_state_r;
        case (spr_state_r)
            SPR_IDLE: begin
                if (run_s && spr_bus_stb_i && !spr_bus_we_i && spr_in_win_s) begin
                    spr_next_s = SPR_RD;
                end else begin
                    spr_next_s = SPR_IDLE;
                end
            end
            SPR_RD:  spr_next_s = spr_bus_stb_i ? SPR_ACK : SPR_IDLE;
            SPR_ACK: spr_next_s = SPR_IDLE;
            default: spr_next_s = SPR_IDLE;
        endcase
    end

    // Shared write port: clear beats writeback beats SPR.
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = {PA{1'b0}};
        mem_wd_s = {W{1'b0}};
        if (!run_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = clr_cnt_r;
        end else if (wb_wr_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = wb_phys_s;
            mem_wd_s = wb_dat_i;
        end else if (spr_wr_req_s && !(R0Z && (spr_bus_addr_i[A-1:0] == {A{1'b0}}))) begin
            mem_we_s = 1'b1;
            mem_wa_s = spr_phys_s;
            mem_wd_s = spr_bus_dat_i;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    assign spr_gpr_ack_o = (spr_state_r == SPR_ACK) || spr_wr_req_s;
    assign spr_gpr_dat_o = (spr_state_r == SPR_ACK) ? spr_q_r : {W{1'b0}};
    assign init_done_o   = init_done_r;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign ram_rd_s[k] = mem_r[{ctx_eff_s, rd_adr_i[k*A +: A]}];

        mor1kx_rf_multiport_rdport #(
            .W       (W),
            .A       (A),
            .CW      (CW),
            .NUM_BYP (NUM_BYP),
            .R0_ZERO (R0Z)
        ) u_rdport (
            .clk       (clk),
            .rst_n     (rst_n),
            .run       (run_s),
            .rd_en     (rd_en_i),
            .rd_adr    (rd_adr_i[k*A +: A]),
            .ctx       (ctx_eff_s),
            .ram_dat   (ram_rd_s[k]),
            .wb_wr     (wb_wr_s),
            .wb_phys   (wb_phys_s),
            .wb_dat    (wb_dat_i),
            .byp_valid (byp_valid_i),
            .byp_adr   (byp_adr_i),
            .byp_dat   (byp_dat_i),
            .rd_dat    (rd_dat_o[k*W +: W])
        );
    end

endmodule

// File: tb/tb_mor1kx_rf_multiport.sv
// Directed and randomized bench for mor1kx_rf_multiport (two banks, two read
// ports, two forwarding stages) against a word-array reference model.
module tb_mor1kx_rf_multiport;

    localparam int W = 32, A = 5, NRD = 2, NBYP = 2, NB = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rd_en;
    logic [NRD*A-1:0]  rd_adr;
    logic [NRD*W-1:0]  rd_dat;
    logic [0:0]        ctx;
    logic [NBYP-1:0]   byp_valid;
    logic [NBYP*A-1:0] byp_adr;
    logic [NBYP*W-1:0] byp_dat;
    logic              wb_we;
    logic [A-1:0]      wb_adr;
    logic [W-1:0]      wb_dat;
    logic [15:0]       spr_addr;
    logic              spr_stb, spr_we;
    logic [W-1:0]      spr_wdat;
    logic              spr_ack;
    logic [W-1:0]      spr_rdat;
    logic              init_done;

    int          total = 0, passed = 0;
    logic [31:0] mmem [64];
    int          mheld [NRD];
    logic [31:0] mval [NRD];
    bit          mrun = 1'b0;

    always #5 clk = ~clk;

    mor1kx_rf_multiport #(
        .OPTION_OPERAND_WIDTH (W), .OPTION_RF_ADDR_WIDTH (A), .NUM_RD (NRD),
        .NUM_BYP (NBYP), .NUM_BANKS (NB), .OPTION_R0_ZERO (1)
    ) dut (
        .clk (clk), .rst_n (rst_n), .rd_en_i (rd_en), .rd_adr_i (rd_adr),
        .rd_dat_o (rd_dat), .ctx_i (ctx), .byp_valid_i (byp_valid),
        .byp_adr_i (byp_adr), .byp_dat_i (byp_dat), .wb_we_i (wb_we),
        .wb_adr_i (wb_adr), .wb_dat_i (wb_dat), .spr_bus_addr_i (spr_addr),
        .spr_bus_stb_i (spr_stb), .spr_bus_we_i (spr_we), .spr_bus_dat_i (spr_wdat),
        .spr_gpr_ack_o (spr_ack), .spr_gpr_dat_o (spr_rdat), .init_done_o (init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        rd_en = 1'b0; byp_valid = '0; byp_adr = '0; byp_dat = '0;
        wb_we = 1'b0; wb_adr = '0; wb_dat = '0;
        spr_stb = 1'b0; spr_we = 1'b0; spr_addr = '0; spr_wdat = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mmem[i] = 32'h0;
        for (int k = 0; k < NRD; k++) begin mheld[k] = 0; mval[k] = 32'h0; end
    endtask

    // Reference: a read port shows the word it latched, updated by any later
    // writeback to that same word (including one in the latch cycle).
    task automatic model_update();
        int  wp;
        bit  wv;
        if (!mrun) return;
        wv = wb_we && (wb_adr != 5'd0);
        wp = int'(ctx) * 32 + int'(wb_adr);
        for (int k = 0; k < NRD; k++) begin
            if (rd_en) begin
                mheld[k] = int'(ctx) * 32 + int'(rd_adr[k*A +: A]);
                mval[k]  = mmem[mheld[k]];
            end
            if (wv && wp == mheld[k]) mval[k] = wb_dat;
        end
        if (wv) mmem[wp] = wb_dat;
    endtask

    function automatic logic [31:0] exp_rd(int k);
        if (mheld[k] % 32 == 0) return 32'h0;
        for (int s = 0; s < NBYP; s++)
            if (byp_valid[s] && (mheld[k] / 32 == int'(ctx)) &&
                (int'(byp_adr[s*A +: A]) == mheld[k] % 32))
                return byp_dat[s*W +: W];
        if (wb_we && wb_adr != 5'd0 && int'(ctx) * 32 + int'(wb_adr) == mheld[k]) return wb_dat;
        return mval[k];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        bit bad = 1'b0;
        while (!init_done && n < 200) begin
            @(posedge clk); #1; n++;
            if (spr_ack !== 1'b0 || rd_dat !== '0) bad = 1'b1;
        end
        chk({tag, "_cycles"}, n, 32'd64);
        chk({tag, "_quiet"}, {31'd0, bad}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(); ctx = 1'b0; rd_adr = '0;
        model_reset();
        #3;
        chk("rst_rd_dat0", rd_dat[31:0], 32'h0);
        chk("rst_rd_dat1", rd_dat[63:32], 32'h0);
        chk("rst_ack", {31'd0, spr_ack}, 32'd0);
        chk("rst_spr_dat", spr_rdat, 32'h0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);

        // Clear sequence with writeback and SPR traffic that must be ignored.
        @(negedge clk) rst_n = 1'b1;
        wb_we = 1'b1; wb_adr = 5'd3; wb_dat = 32'hFFFF;
        spr_stb = 1'b1; spr_we = 1'b1; spr_addr = 16'h0407; spr_wdat = 32'h1111;
        wait_init("clear");
        idle(); mrun = 1'b1;

        // r7 and r3 read back as zero after clearing.
        rd_adr = {5'd3, 5'd7}; rd_en = 1'b1; tick(); rd_en = 1'b0; #2;
        chk("clr_r7", rd_dat[31:0], 32'h0);
        chk("clr_r3", rd_dat[63:32], 32'h0);

        // Writeback in the latch cycle, then while held.
        rd_adr = {5'd3, 5'd3}; rd_en = 1'b1; wb_we = 1'b1; wb_adr = 5'd3; wb_dat = 32'h1234;
        tick(); idle(); #2;
        chk("latch_wb", rd_dat[31:0], 32'h1234);
        wb_we = 1'b1; wb_adr = 5'd3; wb_dat = 32'h55; #1;
        chk("held_wb_live", rd_dat[31:0], 32'h55);
        tick(); idle(); #2;
        chk("held_wb_cap", rd_dat[31:0], 32'h55);

        // Forwarding priority on r5.
        rd_adr = {5'd5, 5'd3}; rd_en = 1'b1; tick(); rd_en = 1'b0;
        byp_valid = 2'b11; byp_adr = {5'd5, 5'd5}; byp_dat = {32'hB, 32'hA};
        wb_we = 1'b1; wb_adr = 5'd5; wb_dat = 32'hC; #2;
        chk("byp0", rd_dat[63:32], 32'hA);
        chk("r3_from_ram", rd_dat[31:0], 32'h55);
        byp_valid = 2'b10; #1;
        chk("byp1", rd_dat[63:32], 32'hB);
        byp_valid = 2'b00; #1;
        chk("byp_wb", rd_dat[63:32], 32'hC);
        tick(); idle(); #2;
        chk("byp_cap", rd_dat[63:32], 32'hC);

        // r0 stays zero against writeback and forwarding.
        rd_adr = '0; rd_en = 1'b1; wb_we = 1'b1; wb_adr = 5'd0; wb_dat = 32'hFFFF;
        tick(); rd_en = 1'b0;
        byp_valid = 2'b01; byp_adr = '0; byp_dat = {32'h0, 32'h99}; #2;
        chk("r0_p0", rd_dat[31:0], 32'h0);
        chk("r0_p1", rd_dat[63:32], 32'h0);
        tick(); idle();

        // SPR write into bank 1, word 4; read via ctx 1 then ctx 0.
        spr_stb = 1'b1; spr_we = 1'b1; spr_addr = 16'h0424; spr_wdat = 32'hDEAD; #2;
        chk("sprw_ack", {31'd0, spr_ack}, 32'd1);
        chk("sprw_dat", spr_rdat, 32'h0);
        tick(); idle(); mmem[36] = 32'hDEAD;
        ctx = 1'b1; rd_adr = {5'd4, 5'd4}; rd_en = 1'b1; tick(); rd_en = 1'b0; #2;
        chk("bank1_r4", rd_dat[31:0], 32'hDEAD);
        ctx = 1'b0; rd_en = 1'b1; tick(); rd_en = 1'b0; #2;
        chk("bank0_r4", rd_dat[31:0], 32'h0);

        // SPR read with writeback forwarded during RD.
        spr_stb = 1'b1; spr_we = 1'b0; spr_addr = 16'h0404; #2;
        chk("sprr_c1", {31'd0, spr_ack}, 32'd0);
        tick(); wb_we = 1'b1; wb_adr = 5'd4; wb_dat = 32'h77; #2;
        chk("sprr_c2", {31'd0, spr_ack}, 32'd0);
        tick(); wb_we = 1'b0; #2;
        chk("sprr_ack", {31'd0, spr_ack}, 32'd1);
        chk("sprr_dat", spr_rdat, 32'h77);
        tick(); spr_stb = 1'b0; #2;
        chk("sprr_done", {31'd0, spr_ack} | spr_rdat, 32'd0);
        spr_stb = 1'b1; spr_addr = 16'h0424; tick(); tick(); #2;
        chk("sprr_bank1", spr_rdat, 32'hDEAD);
        tick(); idle();

        // SPR write stalled by writeback.
        spr_stb = 1'b1; spr_we = 1'b1; spr_addr = 16'h0403; spr_wdat = 32'h3333;
        wb_we = 1'b1; wb_adr = 5'd9; wb_dat = 32'h9; #2;
        chk("stall_c1", {31'd0, spr_ack}, 32'd0);
        tick(); #2;
        chk("stall_c2", {31'd0, spr_ack}, 32'd0);
        tick(); wb_we = 1'b0; #2;
        chk("stall_ack", {31'd0, spr_ack}, 32'd1);
        tick(); idle(); mmem[3] = 32'h3333;
        rd_adr = {5'd9, 5'd3}; rd_en = 1'b1; tick(); rd_en = 1'b0; #2;
        chk("stall_r3", rd_dat[31:0], 32'h3333);
        chk("stall_r9", rd_dat[63:32], 32'h9);

        // Aborted read and out-of-window request never ack.
        spr_stb = 1'b1; spr_addr = 16'h0404; tick(); spr_stb = 1'b0; tick(); #2;
        chk("abort", {31'd0, spr_ack}, 32'd0);
        begin
            bit seen = 1'b0;
            spr_stb = 1'b1; spr_addr = 16'h0604;
            for (int i = 0; i < 4; i++) begin #2; if (spr_ack) seen = 1'b1; tick(); end
            spr_we = 1'b1;
            for (int i = 0; i < 2; i++) begin #2; if (spr_ack) seen = 1'b1; tick(); end
            chk("out_of_window", {31'd0, seen}, 32'd0);
        end
        idle();

        // Randomized reads, writebacks, forwarding and bank switches.
        for (int i = 0; i < 300; i++) begin
            rd_en     = 1'($urandom_range(0, 1));
            rd_adr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            ctx       = ($urandom_range(0, 3) == 0) ? ~ctx : ctx;
            wb_we     = 1'($urandom_range(0, 1));
            wb_adr    = 5'($urandom_range(0, 7));
            wb_dat    = $urandom;
            byp_valid = 2'($urandom_range(0, 3));
            byp_adr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            byp_dat   = {$urandom, $urandom};
            #2;
            chk("rand_p0", rd_dat[31:0], exp_rd(0));
            chk("rand_p1", rd_dat[63:32], exp_rd(1));
            tick();
        end
        idle(); ctx = 1'b0;

        // Reset in the middle of an SPR read restarts clearing.
        spr_stb = 1'b1; spr_addr = 16'h0404; tick();
        rst_n = 1'b0; mrun = 1'b0; model_reset(); #2;
        chk("midrst_ack", {31'd0, spr_ack}, 32'd0);
        chk("midrst_init", {31'd0, init_done}, 32'd0);
        idle();
        @(negedge clk) rst_n = 1'b1;
        wait_init("reclear");
        mrun = 1'b1;
        rd_adr = {5'd9, 5'd3}; rd_en = 1'b1; tick(); rd_en = 1'b0; #2;
        chk("reclear_r3", rd_dat[31:0], 32'h0);
        chk("reclear_r9", rd_dat[63:32], 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
